// File: rtl/yuyv_blk_fetch_if.sv
// yuyv_blk_fetch_if: frame-buffer read port and output FIFO port of yuyv_blk_fetch
interface yuyv_blk_fetch_if #(
   parameter int ADDR_W  = 17,
   parameter int FIFO_AW = 9
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_busy;
   logic              out_rd;
   logic [7:0]        out_data;
   logic [FIFO_AW:0]  out_level;
   logic              blk_rdy;
   logic              frame_done;
   modport master (
      output mem_addr, out_data, out_level, blk_rdy, frame_done,
      input  mem_data, mem_busy, out_rd
   );
   modport slave (
      input  mem_addr, out_data, out_level, blk_rdy, frame_done,
      output mem_data, mem_busy, out_rd
   );
endinterface

// File: rtl/yuyv_blk_fetch.sv
// yuyv_blk_fetch: reads a YUYV frame in 8x8-block order, XOR-80 level-shifts it and queues the bytes in a FIFO.
// Optional macro YUV422_OUT_EN: emit 4:2:2 (Y0 U Y1 V) instead of 4:4:4 (Y0 U V Y1 U V).
module yuyv_blk_fetch #(
   parameter int IMG_W   = 320,
   parameter int IMG_H   = 200,
   parameter int ADDR_W  = 17,
   parameter int FIFO_AW = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             img_req,
   output logic             busy,
   yuyv_blk_fetch_if.master bus
);
`ifdef YUV422_OUT_EN
   localparam int NB = 4;
`else
   localparam int NB = 6;
`endif
   localparam int BXN   = IMG_W / 8;
   localparam int BYN   = IMG_H / 8;
   localparam int BXW   = $clog2(BXN + 1);
   localparam int BYW   = $clog2(BYN + 1);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam logic [BXW-1:0] BX_L  = BXW'(BXN - 1);
   localparam logic [BYW-1:0] BY_L  = BYW'(BYN - 1);
   localparam logic [2:0]     EMI_L = 3'(NB - 1);

   typedef enum logic [2:0] {IDLE, CHK, FETCH, EMIT, NEXT} state_t;

   state_t             state_q, state_d;
   logic [2:0]         req_q, req_d;
   logic [BXW-1:0]     bx_q, bx_d;
   logic [BYW-1:0]     by_q, by_d;
   logic [2:0]         row_q, row_d;
   logic [1:0]         pr_q, pr_d;
   logic [1:0]         iss_q, iss_d;
   logic               pend_q, pend_d;
   logic [1:0]         pidx_q, pidx_d;
   logic [3:0][7:0]    byt_q, byt_d;
   logic [2:0]         emi_q, emi_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               blk_q, blk_d, fd_q, fd_d, busy_q, busy_d;
   logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [FIFO_AW:0]   lvl_q, lvl_d;
   logic [7:0]         dout_q, dout_d;
   logic [7:0]         fifo_q [DEPTH];
   logic [31:0]        px, py;
   logic [ADDR_W-1:0]  base;
   logic [1:0]         sel;
   logic [7:0]         wbyte;
   logic               push, pop, last_pair, last_blk;

   assign py        = 32'(by_q) * 8 + 32'(row_q);
   assign px        = 32'(bx_q) * 8 + 32'(pr_q) * 2;
   assign base      = ADDR_W'((py * IMG_W + px) * 2);
   assign last_pair = pr_q == 2'd3 && row_q == 3'd7;
   assign last_blk  = last_pair && bx_q == BX_L && by_q == BY_L;
   assign push      = state_q == EMIT;
   assign pop       = bus.out_rd && lvl_q != '0;
`ifdef YUV422_OUT_EN
   assign sel = emi_q[1:0];
`else
   assign sel = emi_q == 3'd0 ? 2'd0 : emi_q == 3'd3 ? 2'd2 : emi_q == 3'd2 || emi_q == 3'd5 ? 2'd3 : 2'd1;
`endif
   assign wbyte = byt_q[sel] ^ 8'h80;

   assign bus.mem_addr   = addr_q;
   assign bus.out_data   = dout_q;
   assign bus.out_level  = lvl_q;
   assign bus.blk_rdy    = blk_q;
   assign bus.frame_done = fd_q;
   assign busy           = busy_q;

   // sequencing: request edge, FIFO-space check, stallable 4-byte fetch, emission, pointer advance
   always_comb begin
      state_d = state_q;
      req_d   = {req_q[1:0], img_req};
      bx_d    = bx_q;
      by_d    = by_q;
      row_d   = row_q;
      pr_d    = pr_q;
      iss_d   = iss_q;
      emi_d   = emi_q;
      addr_d  = addr_q;
      pend_d  = 1'b0;
      pidx_d  = iss_q;
      byt_d   = byt_q;
      if (pend_q) byt_d[pidx_q] = bus.mem_data;
      blk_d   = 1'b0;
      fd_d    = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: if (req_q[1] && !req_q[2]) begin
            state_d = CHK;
            busy_d  = 1'b1;
         end
         CHK: if (int'(lvl_q) <= DEPTH - NB) begin
            state_d = FETCH;
            addr_d  = base;
            iss_d   = 2'd0;
         end
         FETCH: if (!bus.mem_busy) begin
            pend_d  = 1'b1;
            iss_d   = iss_q + 2'd1;
            addr_d  = iss_q == 2'd3 ? addr_q : base + ADDR_W'(iss_q + 2'd1);
            state_d = iss_q == 2'd3 ? EMIT : FETCH;
            emi_d   = 3'd0;
         end
         EMIT: begin
            emi_d = emi_q + 3'd1;
            if (emi_q == EMI_L) begin
               state_d = NEXT;
               blk_d   = last_pair;
               fd_d    = last_blk;
               busy_d  = !last_blk;
            end
         end
         NEXT: begin
            pr_d    = pr_q + 2'd1;
            row_d   = pr_q == 2'd3 ? row_q + 3'd1 : row_q;
            bx_d    = last_pair ? (bx_q == BX_L ? '0 : bx_q + BXW'(1)) : bx_q;
            by_d    = last_pair && bx_q == BX_L ? (by_q == BY_L ? '0 : by_q + BYW'(1)) : by_q;
            state_d = last_blk ? IDLE : CHK;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers, fill level and registered head byte
   always_comb begin
      wp_d   = push ? wp_q + FIFO_AW'(1) : wp_q;
      rp_d   = pop ? rp_q + FIFO_AW'(1) : rp_q;
      lvl_d  = lvl_q + LW'(push) - LW'(pop);
      dout_d = pop ? fifo_q[rp_q] : dout_q;
   end

   // state registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         row_q   <= '0;
         pr_q    <= '0;
         iss_q   <= '0;
         pend_q  <= 1'b0;
         pidx_q  <= '0;
         byt_q   <= '0;
         emi_q   <= '0;
         addr_q  <= '0;
         blk_q   <= 1'b0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
         lvl_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         row_q   <= row_d;
         pr_q    <= pr_d;
         iss_q   <= iss_d;
         pend_q  <= pend_d;
         pidx_q  <= pidx_d;
         byt_q   <= byt_d;
         emi_q   <= emi_d;
         addr_q  <= addr_d;
         blk_q   <= blk_d;
         fd_q    <= fd_d;
         busy_q  <= busy_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         lvl_q   <= lvl_d;
         dout_q  <= dout_d;
      end
   end

   // FIFO storage; contents need no reset because level and pointers are cleared
   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= wbyte;
   end
endmodule

// File: tb/tb_yuyv_blk_fetch.sv
// tb_yuyv_blk_fetch: scenario tasks against a frame-level reference model of the block-order YUYV fetcher
module tb_yuyv_blk_fetch;
   localparam int W = 16, H = 16, AW = 9, FAW = 6, DEPTH = 64;
`ifdef YUV422_OUT_EN
   localparam int BPP = 4;
`else
   localparam int BPP = 6;
`endif
   localparam int BLK   = 32 * BPP;
   localparam int TOTAL = (W * H / 2) * BPP;
   localparam int FILL  = DEPTH - (DEPTH % BPP);
   localparam int NEED  = BPP - (DEPTH - FILL);

   logic clk = 0, reset_n = 0, img_req = 0, busy;
   yuyv_blk_fetch_if #(.ADDR_W(AW), .FIFO_AW(FAW)) bus ();
   yuyv_blk_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FIFO_AW(FAW)) dut (
      .clk(clk), .reset_n(reset_n), .img_req(img_req), .busy(busy), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [7:0] ram [512];
   logic [7:0] exp_q [$];
   logic [7:0] got [$];
   int blk_at [$], fd_at [$];
   logic [AW-1:0] alog [$];
   int rd_mode = 0, busy_mode = 0, pops_req = 0;
   logic pop_pend = 0;

   always @(posedge clk) bus.mem_data <= bus.mem_busy ? 8'($urandom) : ram[bus.mem_addr];

   always @(negedge clk) begin
      if (!reset_n) pop_pend = 0;
      if (pop_pend) got.push_back(bus.out_data);
      if (bus.blk_rdy) blk_at.push_back(int'(bus.out_level) + got.size());
      if (bus.frame_done) fd_at.push_back(int'(bus.out_level) + got.size());
      if (alog.size() == 0 || bus.mem_addr != alog[$]) alog.push_back(bus.mem_addr);
      case (rd_mode)
         0: bus.out_rd = 1'b0;
         1: bus.out_rd = 1'b1;
         2: bus.out_rd = 1'($urandom_range(0, 1));
         default: begin
            bus.out_rd = pops_req > 0;
            if (pops_req > 0) pops_req--;
         end
      endcase
      bus.mem_busy = busy_mode == 1 ? !bus.mem_busy : busy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      pop_pend = bus.out_rd && bus.out_level != 0 && reset_n;
   end

   task automatic build_exp();
      int a;
      logic [7:0] y0, u, y1, v;
      exp_q.delete();
      for (int by = 0; by < H / 8; by++)
         for (int bx = 0; bx < W / 8; bx++)
            for (int r = 0; r < 8; r++)
               for (int p = 0; p < 4; p++) begin
                  a  = 2 * ((by * 8 + r) * W + bx * 8 + 2 * p);
                  y0 = ram[a] ^ 8'h80;
                  u  = ram[a + 1] ^ 8'h80;
                  y1 = ram[a + 2] ^ 8'h80;
                  v  = ram[a + 3] ^ 8'h80;
`ifdef YUV422_OUT_EN
                  exp_q.push_back(y0); exp_q.push_back(u); exp_q.push_back(y1); exp_q.push_back(v);
`else
                  exp_q.push_back(y0); exp_q.push_back(u); exp_q.push_back(v);
                  exp_q.push_back(y1); exp_q.push_back(u); exp_q.push_back(v);
`endif
               end
   endtask

   function automatic int stream_err();
      int e = got.size() > exp_q.size() ? got.size() - exp_q.size() : exp_q.size() - got.size();
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) e++;
      return e;
   endfunction

   task automatic clear_logs();
      got.delete();
      blk_at.delete();
      fd_at.delete();
      alog.delete();
      alog.push_back(bus.mem_addr);
   endtask

   task automatic start_frame();
      @(negedge clk) img_req = 1;
      repeat (3) @(negedge clk);
      img_req = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_fd(input int n, output bit ok);
      ok = 0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         ok = fd_at.size() >= n;
      end
   endtask

   task automatic test_reset();
      checks += 6;
      if (bus.mem_addr !== 0) begin failures++; $display("FAIL reset_addr: got %0h want 0", bus.mem_addr); end
      if (bus.out_data !== 0) begin failures++; $display("FAIL reset_data: got %0h want 0", bus.out_data); end
      if (bus.out_level !== 0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.out_level); end
      if (bus.blk_rdy !== 0) begin failures++; $display("FAIL reset_blk: got %b want 0", bus.blk_rdy); end
      if (bus.frame_done !== 0) begin failures++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
      if (busy !== 0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_stream();
      bit ok, bad;
      int e;
      for (int i = 0; i < 512; i++) ram[i] = 8'(i);
      build_exp();
      rd_mode = 1;
      busy_mode = 0;
      clear_logs();
      start_frame();
      checks++;
      if (busy !== 1) begin failures++; $display("FAIL stream_busy: got %b want 1", busy); end
      wait_fd(1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stream_fd: got %0d frame_done want 1", fd_at.size()); end
      repeat (50) @(negedge clk);
      checks++;
      if (got.size() < 6) begin failures++; $display("FAIL stream_first: got %0d bytes want >= 6", got.size()); end
`ifdef YUV422_OUT_EN
      else if ({got[0], got[1], got[2], got[3]} !== 32'h80818283) begin
         failures++; $display("FAIL stream_first: got %h want 80818283", {got[0], got[1], got[2], got[3]});
      end
`else
      else if ({got[0], got[1], got[2], got[3], got[4], got[5]} !== 48'h808183828183) begin
         failures++; $display("FAIL stream_first: got %h want 808183828183", {got[0], got[1], got[2], got[3], got[4], got[5]});
      end
`endif
      e = stream_err();
      checks++;
      if (e != 0) begin failures++; $display("FAIL stream_data: got %0d bad bytes (size %0d) want 0 (size %0d)", e, got.size(), exp_q.size()); end
      bad = blk_at.size() != 4;
      foreach (blk_at[i]) if (blk_at[i] != (i + 1) * BLK) bad = 1;
      checks++;
      if (bad) begin failures++; $display("FAIL stream_blk: got %0d pulses first at %0d want 4 at multiples of %0d", blk_at.size(), blk_at.size() ? blk_at[0] : -1, BLK); end
      checks++;
      if (fd_at.size() != 1 || fd_at[0] != TOTAL) begin failures++; $display("FAIL stream_fdpos: got %0d want %0d", fd_at.size() ? fd_at[0] : -1, TOTAL); end
      checks += 3;
      if (alog.size() <= 256) begin failures += 3; $display("FAIL stream_addr: got %0d addresses want > 256", alog.size()); end
      else begin
         if (alog[16] !== 32) begin failures++; $display("FAIL addr_pair4: got %0d want 32", alog[16]); end
         if (alog[128] !== 16) begin failures++; $display("FAIL addr_blk1: got %0d want 16", alog[128]); end
         if (alog[256] !== 256) begin failures++; $display("FAIL addr_blk2: got %0d want 256", alog[256]); end
      end
      checks++;
      if (busy !== 0) begin failures++; $display("FAIL stream_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_restart();
      bit ok;
      int e;
      clear_logs();
      start_frame();
      wait_fd(1, ok);
      repeat (50) @(negedge clk);
      checks += 2;
      if (alog.size() < 2 || alog[1] !== 0) begin failures++; $display("FAIL restart_addr: got %0d want 0", alog.size() > 1 ? int'(alog[1]) : -1); end
      e = stream_err();
      if (!ok || e != 0) begin failures++; $display("FAIL restart_data: got %0d bad bytes want 0", e); end
   endtask

   task automatic test_stall();
      bit ok;
      int e;
      for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
      build_exp();
      for (int pass = 0; pass < 2; pass++) begin
         busy_mode = pass == 0 ? 1 : 2;
         rd_mode = pass == 0 ? 1 : 2;
         clear_logs();
         start_frame();
         repeat (300) @(negedge clk);
         start_frame();
         wait_fd(1, ok);
         repeat (400) @(negedge clk);
         e = stream_err();
         checks += 3;
         if (!ok || e != 0) begin failures++; $display("FAIL stall_data%0d: got %0d bad bytes want 0", pass, e); end
         if (fd_at.size() != 1) begin failures++; $display("FAIL stall_fdcount%0d: got %0d want 1", pass, fd_at.size()); end
         if (busy !== 0) begin failures++; $display("FAIL stall_noqueue%0d: got busy %b want 0", pass, busy); end
      end
      busy_mode = 0;
      rd_mode = 1;
   endtask

   task automatic test_fifo_full();
      bit ok;
      int e;
      for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
      build_exp();
      rd_mode = 3;
      pops_req = 0;
      clear_logs();
      start_frame();
      repeat (300) @(negedge clk);
      checks += 2;
      if (bus.out_level !== FILL) begin failures++; $display("FAIL full_level: got %0d want %0d", bus.out_level, FILL); end
      if (busy !== 1) begin failures++; $display("FAIL full_busy: got %b want 1", busy); end
      pops_req = 1;
      repeat (40) @(negedge clk);
      checks++;
      if (bus.out_level !== FILL - 1) begin failures++; $display("FAIL full_onepop: got %0d want %0d", bus.out_level, FILL - 1); end
      pops_req = NEED - 1;
      repeat (40) @(negedge clk);
      checks++;
      if (bus.out_level !== FILL - NEED + BPP) begin failures++; $display("FAIL full_resume: got %0d want %0d", bus.out_level, FILL - NEED + BPP); end
      rd_mode = 1;
      wait_fd(1, ok);
      repeat (50) @(negedge clk);
      e = stream_err();
      checks++;
      if (!ok || e != 0) begin failures++; $display("FAIL full_data: got %0d bad bytes want 0", e); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int e;
      rd_mode = 3;
      pops_req = 0;
      clear_logs();
      start_frame();
      for (int i = 0; i < 500 && bus.out_level != 9; i++) @(negedge clk);
      checks++;
      if (bus.out_level !== 9) begin failures++; $display("FAIL mid_reach: got level %0d want 9", bus.out_level); end
      reset_n = 0;
      #1;
      test_reset();
      repeat (3) @(negedge clk);
      reset_n = 1;
      rd_mode = 1;
      clear_logs();
      start_frame();
      wait_fd(1, ok);
      repeat (50) @(negedge clk);
      e = stream_err();
      checks += 2;
      if (got.size() == 0 || got[0] !== (ram[0] ^ 8'h80)) begin failures++; $display("FAIL mid_first: got %0h want %0h", got.size() ? got[0] : 8'hxx, ram[0] ^ 8'h80); end
      if (!ok || e != 0) begin failures++; $display("FAIL mid_data: got %0d bad bytes want 0", e); end
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset_n = 1;
      repeat (2) @(negedge clk);
      test_reset();
      test_stream();
      test_restart();
      test_stall();
      test_fifo_full();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
